cache_arbiter: RTL

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter_pkg.sv | 28 ++
 rtl/cache_arbiter_grant.sv | 56 +++++
 rtl/cache_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/cache_arbiter_pkg.sv
// ============================================================================
// Package     : arbiter_types
// Description : Shared state encoding and default widths for the cache
//               arbiter between the instruction and data caches.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arbiter_types;

    localparam int unsigned LINE_WIDTH_DEF = 256;
    localparam int unsigned ADDR_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    // True while a transfer owns physical memory
    function automatic logic is_serve(arb_state_t s);
        return (s == SERVE_I) || (s == SERVE_D);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cache_arbiter_grant.sv
// ============================================================================
// Module      : arbiter_grant
// Description : Grant selection between instruction and data requesters.
//               With ARBITER_ROUND_ROBIN_EN defined, contention is resolved
//               by a 1-bit pointer favouring the requester not served last;
//               otherwise data always wins over instruction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbiter_grant (
`ifdef ARBITER_ROUND_ROBIN_EN
    input  logic clk,
    input  logic rst,
    input  logic en_i,
`endif
    input  logic i_req_i,
    input  logic d_req_i,
    output logic valid_o,
    output logic grant_d_o
);

`ifdef ARBITER_ROUND_ROBIN_EN
    // ptr_q = 1 means data is preferred on the next contention
    logic ptr_q;
    logic ptr_d;

    // Pick a winner and flip the preference away from it on each grant
    always_comb begin
        valid_o   = i_req_i | d_req_i;
        grant_d_o = (i_req_i && d_req_i) ? ptr_q : d_req_i;
        ptr_d     = ptr_q;
        if (en_i && valid_o) begin
            ptr_d = ~grant_d_o;
        end
    end

    // Pointer register; reset favours data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= 1'b1;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: any data request beats an instruction request
    always_comb begin
        valid_o   = i_req_i | d_req_i;
        grant_d_o = d_req_i;
    end
`endif

endmodule

`default_nettype wire

// File: rtl/cache_arbiter.sv
// ============================================================================
// Module      : cache_arbiter
// Description : Arbitrates instruction- and data-cache line transfers onto a
//               single physical memory port. The granted request is latched
//               so the memory command is stable for the whole transfer; a
//               one-cycle RELEASE state lets the requester drop its request.
//               Macro ARBITER_ROUND_ROBIN_EN selects round-robin arbitration
//               (default: fixed data-over-instruction priority).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_arbiter
    import arbiter_types::*;
#(
    parameter int unsigned LINE_WIDTH = LINE_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_resp,
    output logic [LINE_WIDTH-1:0] i_rdata,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic                  d_resp,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_addr,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    arb_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic                  write_q, write_d;

    logic gnt_valid;
    logic gnt_d;
    logic serve;

    arbiter_grant u_grant (
`ifdef ARBITER_ROUND_ROBIN_EN
        .clk       (clk),
        .rst       (rst),
        .en_i      (state_q == IDLE),
`endif
        .i_req_i   (i_read),
        .d_req_i   (d_read | d_write),
        .valid_o   (gnt_valid),
        .grant_d_o (gnt_d)
    );

    // Next-state logic; the request is captured only on the grant edge
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d = gnt_d ? SERVE_D : SERVE_I;
                    addr_d  = gnt_d ? d_addr : i_addr;
                    wdata_d = gnt_d ? d_wdata : '0;
                    // A simultaneous read and write is treated as a write
                    write_d = gnt_d & d_write;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and latched-request registers; reset aborts any transfer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
        end
    end

    // Memory command comes only from the latched request, only while serving
    always_comb begin
        serve      = is_serve(state_q);
        pmem_read  = serve & ~write_q;
        pmem_write = serve &  write_q;
        pmem_addr  = serve ? addr_q  : '0;
        pmem_wdata = serve ? wdata_q : '0;
        i_resp     = (state_q == SERVE_I) & pmem_resp;
        d_resp     = (state_q == SERVE_D) & pmem_resp;
        i_rdata    = pmem_rdata;
        d_rdata    = pmem_rdata;
    end

endmodule

`default_nettype wire
